// File: rtl/ysyx_22040237_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encodings, owner codes
// and the timeout counter width helper.
package ysyx_22040237_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2,
        ARB_RET  = 2'd3
    } arb_state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // A timeout of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ysyx_22040237_arb_timeout_cnt.sv
// Saturating RESP-phase cycle counter; expires on the last allowed waiting cycle.
module ysyx_22040237_arb_timeout_cnt
    import ysyx_22040237_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/ysyx_22040237_mem_arbiter.sv
// Single-port memory arbiter: LSU has fixed priority over IFU, one transaction in
// flight, registered request/response payloads, response timeout with late-response drain.
//
//   state | meaning
//   IDLE  | arbitrate (only when no drain is pending)
//   REQ   | present latched request to memory until accepted
//   RESP  | wait for memory response, counting cycles toward timeout
//   RET   | hold response to the owner until it is accepted
module ysyx_22040237_mem_arbiter
    import ysyx_22040237_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    input  logic                mem_resp_err,

    output logic                busy_o
);

    arb_state_t          r_state;
    logic                r_owner;
    logic                r_drain;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_mem_req_valid;
    logic                r_mem_resp_ready;
    logic                r_ifu_resp_valid;
    logic                r_lsu_resp_valid;

    logic w_arb_en;
    logic w_lsu_grant;
    logic w_ifu_grant;
    logic w_owner_ready;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expire;

    // Readies are gated by rst_n so every output reads 0 while reset is held.
    assign w_arb_en      = rst_n && (r_state == ARB_IDLE) && !r_drain;
    assign w_lsu_grant   = w_arb_en && lsu_req_valid;
    assign w_ifu_grant   = w_arb_en && !lsu_req_valid && ifu_req_valid;
    assign w_owner_ready = (r_owner == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign w_cnt_clear   = (r_state == ARB_REQ) && mem_req_ready;
    assign w_cnt_en      = (r_state == ARB_RESP);

    ysyx_22040237_arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ARB_IDLE;
            r_owner          <= OWNER_IFU;
            r_drain          <= 1'b0;
            r_addr           <= '0;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_wstrb          <= '0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            // A drain is only pending outside RESP, so this never races the RESP branch.
            if (r_drain && mem_resp_valid) begin
                r_drain          <= 1'b0;
                r_mem_resp_ready <= 1'b0;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_lsu_grant) begin
                        r_owner         <= OWNER_LSU;
                        r_addr          <= lsu_req_addr;
                        r_wen           <= lsu_req_wen;
                        r_wdata         <= lsu_req_wdata;
                        r_wstrb         <= lsu_req_wstrb;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ARB_REQ;
                    end else if (w_ifu_grant) begin
                        r_owner         <= OWNER_IFU;
                        r_addr          <= ifu_req_addr;
                        r_wen           <= 1'b0;
                        r_wdata         <= '0;
                        r_wstrb         <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid  <= 1'b0;
                        r_mem_resp_ready <= 1'b1;
                        r_state          <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_resp_valid) begin
                        r_rdata          <= mem_resp_rdata;
                        r_err            <= mem_resp_err;
                        r_mem_resp_ready <= 1'b0;
                        r_ifu_resp_valid <= (r_owner == OWNER_IFU);
                        r_lsu_resp_valid <= (r_owner == OWNER_LSU);
                        r_state          <= ARB_RET;
                    end else if (w_expire) begin
                        // Keep mem_resp_ready high so the late response is swallowed.
                        r_rdata          <= '0;
                        r_err            <= 1'b1;
                        r_drain          <= 1'b1;
                        r_ifu_resp_valid <= (r_owner == OWNER_IFU);
                        r_lsu_resp_valid <= (r_owner == OWNER_LSU);
                        r_state          <= ARB_RET;
                    end
                end
                ARB_RET: begin
                    if (w_owner_ready) begin
                        r_ifu_resp_valid <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_state          <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = w_ifu_grant;
    assign lsu_req_ready  = w_lsu_grant;

    assign mem_req_valid  = r_mem_req_valid;
    assign mem_req_addr   = r_addr;
    assign mem_req_wen    = r_wen;
    assign mem_req_wdata  = r_wdata;
    assign mem_req_wstrb  = r_wstrb;
    assign mem_resp_ready = r_mem_resp_ready;

    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_resp_rdata = r_rdata;
    assign ifu_resp_err   = r_err;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_resp_rdata = r_rdata;
    assign lsu_resp_err   = r_err;

    assign busy_o = (r_state != ARB_IDLE) || r_drain;

endmodule
